// File: rtl/reg_trace_feeder.sv
// Captures each change of a watched register into a small FIFO and replays the
// captured values to the display, holding each one for a fixed number of cycles.
module reg_trace_feeder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned HOLD_W      = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        sample_i,
  input  logic                     sample_en_i,
  input  logic                     clear_i,
  output logic [DATA_W-1:0]        disp_o,
  output logic                     disp_valid_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0]     FULL_LEVEL  = LW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   cnt;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [DATA_W-1:0]   prev;
  logic                first;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                change_c;
  logic                pop_c;
  logic                push_c;
  logic                empty_c;
  logic                full_c;
  logic [DATA_W-1:0]   head_c;

  // Change detect, pop decision and push acceptance; pops see only stored entries
  always_comb begin
    change_c = 1'b0;
    pop_c    = 1'b0;
    push_c   = 1'b0;
    empty_c  = (level_o == '0);
    full_c   = (level_o == FULL_LEVEL);
    head_c   = mem[rd_ptr];
    if (!clear_i) begin
      change_c = sample_en_i && (first || (sample_i != prev));
      if (!empty_c) begin
        pop_c = (state == IDLE) || (cnt == '0);
      end
      push_c = change_c && (!full_c || pop_c);
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= sample_i;
    end
  end

  // FIFO bookkeeping, change tracking and the IDLE/HOLD replay machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_o      <= '0;
      prev         <= '0;
      first        <= 1'b1;
      overflow_o   <= 1'b0;
      disp_o       <= '0;
      disp_valid_o <= 1'b0;
    end else if (clear_i) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_o      <= '0;
      first        <= 1'b1;
      overflow_o   <= 1'b0;
      disp_o       <= '0;
      disp_valid_o <= 1'b0;
    end else begin
      // A dropped value still updates prev so it is not retried next cycle
      if (change_c) begin
        prev  <= sample_i;
        first <= 1'b0;
        if (!push_c) begin
          overflow_o <= 1'b1;
        end
      end

      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push_c, pop_c})
        2'b10:   level_o <= level_o + LW'(1);
        2'b01:   level_o <= level_o - LW'(1);
        default: level_o <= level_o;
      endcase

      case (state)
        IDLE: begin
          if (pop_c) begin
            disp_o       <= head_c;
            disp_valid_o <= 1'b1;
            cnt          <= HOLD_RELOAD;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - HOLD_W'(1);
          end else if (pop_c) begin
            disp_o <= head_c;
            cnt    <= HOLD_RELOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_trace_feeder.sv
// Directed bench for reg_trace_feeder: stimulus queues expected presentations
// (value and cycle), an independent monitor matches them as disp_o changes.
module tb_reg_trace_feeder;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned HOLD_CYCLES = 4;
  localparam int unsigned HOLD_W      = 3;
  localparam int unsigned LW          = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] sample;
  logic              sample_en;
  logic              clear;
  logic [DATA_W-1:0] disp_o;
  logic              disp_valid_o;
  logic              overflow_o;
  logic [LW-1:0]     level_o;

  reg_trace_feeder #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD_CYCLES),
    .HOLD_W      (HOLD_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_i     (sample),
    .sample_en_i  (sample_en),
    .clear_i      (clear),
    .disp_o       (disp_o),
    .disp_valid_o (disp_valid_o),
    .overflow_o   (overflow_o),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a new presentation is a rising disp_valid_o or a change of disp_o
  logic        prev_valid = 1'b0;
  logic [31:0] prev_disp  = '0;
  always @(negedge clk) begin
    exp_t e;
    if (disp_valid_o && (!prev_valid || disp_o != prev_disp)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL present: unexpected disp_o=%h at cycle %0d", disp_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (disp_o !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL present: got %h at cycle %0d, expected %h at cycle %0d",
                   disp_o, cyc, e.data, e.due);
        end
      end
    end
    prev_valid = disp_valid_o;
    prev_disp  = disp_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_show(input logic [31:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic en, input logic [31:0] v);
    @(negedge clk);
    sample_en = en;
    sample    = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int q;
    int r;
    rst_n = 1'b0; clear = 1'b0; sample_en = 1'b0; sample = '0;
    #3;
    check("reset disp", disp_o, 32'h0);
    check("reset valid", 32'(disp_valid_o), 32'h0);
    check("reset ovf", 32'(overflow_o), 32'h0);
    check("reset level", 32'(level_o), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First capture of value 0, then identical samples must not push
    drive(1'b1, 32'h0); t = cyc;
    expect_show(32'h0, t + 2);
    drive(1'b1, 32'h0);
    check("first level", 32'(level_o), 32'h1);
    drive(1'b1, 32'h0);
    check("same no push a", 32'(level_o), 32'h0);
    drive(1'b0, 32'h0);
    check("same no push b", 32'(level_o), 32'h0);
    repeat (4) @(negedge clk);

    // Backlog pacing: one value per 4 cycles
    drive(1'b1, 32'h11); t = cyc;
    expect_show(32'h11, t + 2);
    expect_show(32'h22, t + 6);
    expect_show(32'h33, t + 10);
    drive(1'b1, 32'h22);
    drive(1'b1, 32'h33);
    drive(1'b0, 32'h33);
    while (cyc < t + 14) @(negedge clk);
    check("backlog disp", disp_o, 32'h33);
    check("backlog valid", 32'(disp_valid_o), 32'h1);
    check("backlog level", 32'(level_o), 32'h0);

    // Overflow: five values into a HOLD with one entry queued; the fifth drops
    drive(1'b1, 32'hA0); q = cyc;
    expect_show(32'hA0, q + 2);
    expect_show(32'hA1, q + 6);
    expect_show(32'hB1, q + 10);
    expect_show(32'hB2, q + 14);
    expect_show(32'hB3, q + 18);
    expect_show(32'hB4, q + 22);
    expect_show(32'hB6, q + 26);
    drive(1'b1, 32'hA1);
    drive(1'b1, 32'hB1);
    drive(1'b1, 32'hB2);
    drive(1'b1, 32'hB3);
    drive(1'b1, 32'hB4);
    check("fill level", 32'(level_o), 32'h4);
    check("fill ovf", 32'(overflow_o), 32'h0);
    drive(1'b1, 32'hB5);
    check("full+pop level", 32'(level_o), 32'h4);
    check("full+pop ovf", 32'(overflow_o), 32'h0);
    drive(1'b0, 32'hB5);
    check("drop level", 32'(level_o), 32'h4);
    check("drop ovf", 32'(overflow_o), 32'h1);
    drive(1'b0, 32'hB5);
    drive(1'b1, 32'hB6);
    drive(1'b0, 32'hB6);
    check("full+pop2 level", 32'(level_o), 32'h4);
    check("full+pop2 ovf", 32'(overflow_o), 32'h1);

    // Clear mid-HOLD with three entries queued; clear-cycle sample is ignored
    while (cyc < q + 15) @(negedge clk);
    check("pre-clear level", 32'(level_o), 32'h3);
    clear = 1'b1; sample_en = 1'b1; sample = 32'h99;
    @(negedge clk);
    clear = 1'b0;
    exp_q.delete();
    check("clear level", 32'(level_o), 32'h0);
    check("clear disp", disp_o, 32'h0);
    check("clear valid", 32'(disp_valid_o), 32'h0);
    check("clear ovf", 32'(overflow_o), 32'h0);
    sample = 32'hB6;
    expect_show(32'hB6, cyc + 2);
    drive(1'b0, 32'hB6);
    check("post-clear level", 32'(level_o), 32'h1);
    drive(1'b1, 32'hC7);
    drive(1'b0, 32'hC7);
    check("pre-reset level", 32'(level_o), 32'h1);

    // Asynchronous reset between edges during HOLD
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("areset disp", disp_o, 32'h0);
    check("areset valid", 32'(disp_valid_o), 32'h0);
    check("areset ovf", 32'(overflow_o), 32'h0);
    check("areset level", 32'(level_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; sample_en = 1'b1; sample = 32'hC7;
    r = cyc;
    expect_show(32'hC7, r + 2);
    drive(1'b0, 32'hC7);
    check("resume level", 32'(level_o), 32'h1);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain pending", 32'(exp_q.size()), 32'h0);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
